id_stage: RTL

// - Decode stage of the 16-bit pipelined CPU: decodes the IF/ID instruction and reads the 16x16 register file.
// - Produces every input of the ID/EX pipeline register (operands, imm, rd, alu_op, reg_write, mem_read, mem_write).
// - Owns the register-file write port (driven by WB), load-use hazard interlock, and a sticky HALT state.
// - Sits between IF/ID and ID/EX; the stall output holds the PC and IF/ID.

---
 rtl/cpu16_pkg.sv | 46 ++++
 rtl/id_regfile.sv | 63 ++++++
 rtl/id_stage.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/cpu16_pkg.sv
// Shared definitions for the 16-bit pipelined CPU: opcodes, ALU operation
// codes, instruction field positions and immediate sign-extension helpers.
package cpu16_pkg;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_AND  = 4'h3;
   localparam logic [3:0] OP_OR   = 4'h4;
   localparam logic [3:0] OP_XOR  = 4'h5;
   localparam logic [3:0] OP_SHL  = 4'h6;
   localparam logic [3:0] OP_SHR  = 4'h7;
   localparam logic [3:0] OP_ADDI = 4'h8;
   localparam logic [3:0] OP_LW   = 4'h9;
   localparam logic [3:0] OP_SW   = 4'hA;
   localparam logic [3:0] OP_LI   = 4'hB;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [3:0] ALU_NOP   = 4'h0;
   localparam logic [3:0] ALU_ADD   = 4'h1;
   localparam logic [3:0] ALU_SUB   = 4'h2;
   localparam logic [3:0] ALU_AND   = 4'h3;
   localparam logic [3:0] ALU_OR    = 4'h4;
   localparam logic [3:0] ALU_XOR   = 4'h5;
   localparam logic [3:0] ALU_SHL   = 4'h6;
   localparam logic [3:0] ALU_SHR   = 4'h7;
   localparam logic [3:0] ALU_PASSB = 4'hB;

   localparam int OPC_HI = 15;
   localparam int OPC_LO = 12;
   localparam int RD_HI  = 11;
   localparam int RD_LO  = 8;
   localparam int RS1_HI = 7;
   localparam int RS1_LO = 4;
   localparam int RS2_HI = 3;
   localparam int RS2_LO = 0;

   function automatic logic [15:0] sext4(input logic [3:0] v);
      return {{12{v[3]}}, v};
   endfunction

   function automatic logic [15:0] sext8(input logic [7:0] v);
      return {{8{v[7]}}, v};
   endfunction

endpackage

// File: rtl/id_regfile.sv
// 16x16 register file: two asynchronous read ports, one synchronous write
// port, async active-high reset. R0_ZERO makes R0 a hard zero.
// Macro WB_BYPASS_EN: when defined, a same-cycle write is forwarded to reads.
module id_regfile
   import cpu16_pkg::*;
#(
   parameter bit R0_ZERO = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  rd_addr1,
   input  logic [3:0]  rd_addr2,
   output logic [15:0] rd_data1,
   output logic [15:0] rd_data2,
   input  logic        wb_we,
   input  logic [3:0]  wb_rd,
   input  logic [15:0] wb_data
);

   logic [15:0] regs_q [16];
   logic [15:0] regs_d [16];
   logic        write_ok;

   assign write_ok = wb_we && !(R0_ZERO && (wb_rd == 4'd0));

   // Next-state of the array: only the addressed entry changes on a write.
   always_comb begin
      regs_d = regs_q;
      if (write_ok) begin
         regs_d[wb_rd] = wb_data;
      end
   end

   // Register storage, cleared asynchronously by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         regs_q <= '{default: '0};
      end else begin
         regs_q <= regs_d;
      end
   end

   // Read ports, with optional write-through and the hard-zero R0.
   always_comb begin
      rd_data1 = regs_q[rd_addr1];
      rd_data2 = regs_q[rd_addr2];
`ifdef WB_BYPASS_EN
      if (write_ok && (wb_rd == rd_addr1)) begin
         rd_data1 = wb_data;
      end
      if (write_ok && (wb_rd == rd_addr2)) begin
         rd_data2 = wb_data;
      end
`endif
      if (R0_ZERO && (rd_addr1 == 4'd0)) begin
         rd_data1 = '0;
      end
      if (R0_ZERO && (rd_addr2 == 4'd0)) begin
         rd_data2 = '0;
      end
   end

endmodule

// File: rtl/id_stage.sv
// Decode stage of the 16-bit CPU: instruction decode, register read,
// load-use interlock, sticky HALT and a saturating stall-cycle counter.
// Macro WB_BYPASS_EN (in id_regfile) selects write-through register reads.
module id_stage
   import cpu16_pkg::*;
#(
   parameter bit R0_ZERO = 1'b1,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             if_valid,
   input  logic [15:0]      if_instr,
   input  logic             ex_mem_read,
   input  logic [3:0]       ex_rd,
   input  logic             wb_we,
   input  logic [3:0]       wb_rd,
   input  logic [15:0]      wb_data,
   output logic [15:0]      reg_data1,
   output logic [15:0]      reg_data2,
   output logic [15:0]      imm,
   output logic [3:0]       rd,
   output logic [3:0]       alu_op,
   output logic             reg_write,
   output logic             mem_read,
   output logic             mem_write,
   output logic             stall,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt
);

   logic [3:0]       opcode;
   logic [3:0]       rd_f;
   logic [3:0]       rs1_f;
   logic [3:0]       rs2_f;
   logic [3:0]       rf_addr2;
   logic [15:0]      rf_data1;
   logic [15:0]      rf_data2;

   logic             uses_rs1;
   logic             uses_rs2;
   logic             uses_rd_src;
   logic             is_halt;
   logic [3:0]       dec_alu;
   logic [15:0]      dec_imm;
   logic             dec_reg_write;
   logic             dec_mem_read;
   logic             dec_mem_write;

   logic             hazard;
   logic             stall_int;
   logic             bubble;

   logic             halted_q;
   logic             halted_d;
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] stall_cnt_d;

   assign opcode   = if_instr[OPC_HI:OPC_LO];
   assign rd_f     = if_instr[RD_HI:RD_LO];
   assign rs1_f    = if_instr[RS1_HI:RS1_LO];
   assign rs2_f    = if_instr[RS2_HI:RS2_LO];

   // SW reads its store data through port 2 using the rd field.
   assign rf_addr2 = (opcode == OP_SW) ? rd_f : rs2_f;

   id_regfile #(
      .R0_ZERO (R0_ZERO)
   ) u_regfile (
      .clk      (clk),
      .reset    (reset),
      .rd_addr1 (rs1_f),
      .rd_addr2 (rf_addr2),
      .rd_data1 (rf_data1),
      .rd_data2 (rf_data2),
      .wb_we    (wb_we),
      .wb_rd    (wb_rd),
      .wb_data  (wb_data)
   );

   // Opcode decode into control, immediate and source-usage flags.
   always_comb begin
      uses_rs1      = 1'b0;
      uses_rs2      = 1'b0;
      uses_rd_src   = 1'b0;
      is_halt       = 1'b0;
      dec_alu       = ALU_NOP;
      dec_imm       = '0;
      dec_reg_write = 1'b0;
      dec_mem_read  = 1'b0;
      dec_mem_write = 1'b0;
      unique case (opcode)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
            uses_rs1      = 1'b1;
            uses_rs2      = 1'b1;
            dec_alu       = opcode;
            dec_reg_write = 1'b1;
         end
         OP_ADDI: begin
            uses_rs1      = 1'b1;
            dec_alu       = ALU_ADD;
            dec_imm       = sext4(rs2_f);
            dec_reg_write = 1'b1;
         end
         OP_LW: begin
            uses_rs1      = 1'b1;
            dec_alu       = ALU_ADD;
            dec_imm       = sext4(rs2_f);
            dec_reg_write = 1'b1;
            dec_mem_read  = 1'b1;
         end
         OP_SW: begin
            uses_rs1      = 1'b1;
            uses_rd_src   = 1'b1;
            dec_alu       = ALU_ADD;
            dec_imm       = sext4(rs2_f);
            dec_mem_write = 1'b1;
         end
         OP_LI: begin
            dec_alu       = ALU_PASSB;
            dec_imm       = sext8(if_instr[RS1_HI:RS2_LO]);
            dec_reg_write = 1'b1;
         end
         OP_HALT: begin
            is_halt = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Load-use interlock: a load in EX whose destination this instruction reads.
   always_comb begin
      hazard = if_valid && !halted_q && ex_mem_read
               && !(R0_ZERO && (ex_rd == 4'd0))
               && ((uses_rs1 && (ex_rd == rs1_f))
                   || (uses_rs2 && (ex_rd == rs2_f))
                   || (uses_rd_src && (ex_rd == rd_f)));
      stall_int = hazard || halted_q;
      bubble    = reset || !if_valid || stall_int;
   end

   // Drive ID/EX inputs, forcing a bubble when nothing valid may issue.
   always_comb begin
      reg_data1 = '0;
      reg_data2 = '0;
      imm       = '0;
      rd        = '0;
      alu_op    = ALU_NOP;
      reg_write = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      if (!bubble) begin
         reg_data1 = rf_data1;
         reg_data2 = rf_data2;
         imm       = dec_imm;
         rd        = rd_f;
         alu_op    = dec_alu;
         reg_write = dec_reg_write;
         mem_read  = dec_mem_read;
         mem_write = dec_mem_write;
      end
      stall     = stall_int && !reset;
      halted    = halted_q && !reset;
      stall_cnt = reset ? '0 : stall_cnt_q;
   end

   // Next-state for the sticky halt flag and the saturating stall counter.
   always_comb begin
      halted_d    = halted_q || (if_valid && is_halt && !stall_int);
      stall_cnt_d = stall_cnt_q;
      if (stall_int && !(&stall_cnt_q)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   // Halt and counter state, cleared asynchronously by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         halted_q    <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         halted_q    <= halted_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule
